main_memory_responder: RTL and testbench

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

---
 rtl/main_memory_responder_pkg.sv | 10 +
 rtl/main_memory_responder_wait_ctr.sv | 22 ++
 rtl/main_memory_responder.sv | 74 +++++++
 tb/tb_main_memory_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_responder_pkg.sv
// main_memory_responder_pkg: state encoding and default parameters shared by
// the memory responder and its wait counter.
package main_memory_responder_pkg;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 4;
    localparam int CTR_W           = 8;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/main_memory_responder_wait_ctr.sv
// mem_wait_ctr: loadable down-counter that flags when the access edge is due.
module mem_wait_ctr
    import main_memory_responder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             one_o
);
    logic [CTR_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign one_o = cnt_q == CTR_W'(1);
endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: single-outstanding-request memory model with a fixed
// access latency, a one-cycle completion pulse and a sticky protocol-error flag.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              Busy,
    output logic              ProtoErr
);
    state_t              state_q, state_d;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                perr_q, perr_d;
    logic                accept, access, ctr_one;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign accept = state_q == IDLE && MStrobe;
    assign access = state_q == WAIT && ctr_one;

    mem_wait_ctr u_ctr (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .load_val_i(CTR_W'(WAIT_CYCLES)),
        .dec_i     (state_q == WAIT && !ctr_one),
        .one_o     (ctr_one)
    );

    always_comb begin
        state_d = accept ? WAIT : access ? DONE : state_q == DONE ? IDLE : state_q;
        rdata_d = access && !rw_q ? mem[addr_q] : rdata_q;
        perr_d  = perr_q | (MStrobe && state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Request latches and the array carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= MRW;
            addr_q  <= MAddr;
            wdata_q <= MDataIn;
        end
        if (access && rw_q) mem[addr_q] <= wdata_q;
    end

    assign MDataOut = rdata_q;
    assign MReady   = state_q == DONE;
    assign Busy     = state_q != IDLE;
    assign ProtoErr = perr_q;
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: randomized self-checking bench for the memory responder
// against a word-array model with fixed-latency request timing.
module tb_main_memory_responder;
    localparam int W0 = 1;
    localparam int W1 = 4;
    localparam int W2 = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strb [3];
    logic        mrw;
    logic [7:0]  maddr;
    logic [31:0] mdin;
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        bsy  [3];
    logic        perr [3];

    int          wc [3] = '{W0, W1, W2};
    logic [31:0] mdl [256];
    bit          known [256];
    logic [31:0] last_rd = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    main_memory_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset), .MStrobe(strb[0]), .MRW(mrw), .MAddr(maddr), .MDataIn(mdin),
        .MDataOut(dout[0]), .MReady(rdy[0]), .Busy(bsy[0]), .ProtoErr(perr[0]));
    main_memory_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset), .MStrobe(strb[1]), .MRW(mrw), .MAddr(maddr), .MDataIn(mdin),
        .MDataOut(dout[1]), .MReady(rdy[1]), .Busy(bsy[1]), .ProtoErr(perr[1]));
    main_memory_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .reset(reset), .MStrobe(strb[2]), .MRW(mrw), .MAddr(maddr), .MDataIn(mdin),
        .MDataOut(dout[2]), .MReady(rdy[2]), .Busy(bsy[2]), .ProtoErr(perr[2]));

    // One request on the WAIT_CYCLES=4 instance; started just after a rising edge with it idle.
    task automatic run_req(input bit rw, input logic [7:0] a, input logic [31:0] d);
        strb[1] = 1'b1; mrw = rw; maddr = a; mdin = d;
        @(posedge clk); #1;
        strb[1] = 1'b0;
        mrw = 1'($urandom); maddr = 8'($urandom); mdin = $urandom;
        checks++;
        if (bsy[1] !== 1'b1) begin errors++; $display("FAIL req_busy_e0 got %b exp 1", bsy[1]); end
        if (rw) begin mdl[a] = d; known[a] = 1'b1; end
        else last_rd = mdl[a];
        for (int k = 1; k <= W1 + 1; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rdy[1] !== 1'(k == W1)) begin errors++; $display("FAIL req_ready a=%0h k=%0d got %b exp %b", a, k, rdy[1], k == W1); end
            checks++;
            if (bsy[1] !== 1'(k <= W1)) begin errors++; $display("FAIL req_busy a=%0h k=%0d got %b exp %b", a, k, bsy[1], k <= W1); end
        end
        checks++;
        if (dout[1] !== last_rd) begin errors++; $display("FAIL req_dout a=%0h rw=%0b got %h exp %h", a, rw, dout[1], last_rd); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) strb[i] = 1'b0;
        mrw = 1'b0; maddr = '0; mdin = '0;
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rdy[i], bsy[i], perr[i]} !== 3'b000) begin errors++; $display("FAIL reset_flags dut%0d got %b exp 000", i, {rdy[i], bsy[i], perr[i]}); end
            checks++;
            if (dout[i] !== 32'h0) begin errors++; $display("FAIL reset_dout dut%0d got %h exp 0", i, dout[i]); end
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        last_rd = '0;
    endtask

    task automatic test_write_read();
        run_req(1'b1, 8'h10, 32'hDEADBEEF);
        run_req(1'b0, 8'h10, 32'h0);
        checks++;
        if (dout[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read got %h exp deadbeef", dout[1]); end
    endtask

    task automatic test_latency_sweep();
        logic [7:0]  a = 8'h40 + 8'($urandom_range(0, 15));
        logic [31:0] d = $urandom;
        for (int i = 0; i < 3; i++) strb[i] = 1'b1;
        mrw = 1'b1; maddr = a; mdin = d;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) strb[i] = 1'b0;
        mdl[a] = d; known[a] = 1'b1;
        for (int k = 1; k <= W2 + 1; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rdy[i] !== 1'(k == wc[i])) begin errors++; $display("FAIL sweep_ready W=%0d k=%0d got %b exp %b", wc[i], k, rdy[i], k == wc[i]); end
                checks++;
                if (bsy[i] !== 1'(k <= wc[i])) begin errors++; $display("FAIL sweep_busy W=%0d k=%0d got %b exp %b", wc[i], k, bsy[i], k <= wc[i]); end
            end
        end
        run_req(1'b0, a, 32'h0);
    endtask

    task automatic test_inputs_change();
        run_req(1'b1, 8'h11, 32'h1111_0000);
        strb[1] = 1'b1; mrw = 1'b1; maddr = 8'h10; mdin = 32'hCAFE_F00D;
        @(posedge clk); #1;
        strb[1] = 1'b0; maddr = 8'h11; mdin = 32'h0BAD_0BAD; mrw = 1'b0;
        mdl[8'h10] = 32'hCAFE_F00D;
        repeat (W1 + 1) @(posedge clk);
        #1;
        run_req(1'b0, 8'h10, 32'h0);
        run_req(1'b0, 8'h11, 32'h0);
    endtask

    task automatic test_proto_err();
        logic [31:0] d = $urandom;
        run_req(1'b1, 8'h31, 32'h3131_3131);
        strb[1] = 1'b1; mrw = 1'b1; maddr = 8'h30; mdin = d;
        @(posedge clk); #1;
        maddr = 8'h31; mdin = ~d;
        mdl[8'h30] = d;
        for (int k = 1; k <= W1 + 1; k++) begin
            @(posedge clk); #1;
            if (k == 2) strb[1] = 1'b0;
            checks++;
            if (rdy[1] !== 1'(k == W1)) begin errors++; $display("FAIL proto_ready k=%0d got %b exp %b", k, rdy[1], k == W1); end
        end
        checks++;
        if (perr[1] !== 1'b1) begin errors++; $display("FAIL proto_set got %b exp 1", perr[1]); end
        run_req(1'b0, 8'h30, 32'h0);
        run_req(1'b0, 8'h31, 32'h0);
        checks++;
        if (perr[1] !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b exp 1", perr[1]); end
    endtask

    task automatic test_abort();
        run_req(1'b1, 8'h20, 32'h11);
        strb[1] = 1'b1; mrw = 1'b1; maddr = 8'h20; mdin = 32'h55;
        @(posedge clk); #1;
        strb[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        last_rd = '0;
        checks++;
        if ({rdy[1], bsy[1], perr[1]} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b exp 000", {rdy[1], bsy[1], perr[1]}); end
        checks++;
        if (dout[1] !== 32'h0) begin errors++; $display("FAIL abort_dout got %h exp 0", dout[1]); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({rdy[1], bsy[1]} !== 2'b00) begin errors++; $display("FAIL abort_idle k=%0d got %b exp 00", k, {rdy[1], bsy[1]}); end
        end
        run_req(1'b0, 8'h20, 32'h0);
    endtask

    task automatic test_back_to_back();
        run_req(1'b1, 8'h50, 32'h5050_5050);
        run_req(1'b1, 8'h51, 32'h5151_5151);
        checks++;
        if (perr[1] !== 1'b0) begin errors++; $display("FAIL b2b_accept_perr got %b exp 0", perr[1]); end
        strb[1] = 1'b1; mrw = 1'b0; maddr = 8'h50;
        @(posedge clk); #1;
        strb[1] = 1'b0;
        last_rd = mdl[8'h50];
        repeat (W1) @(posedge clk);
        #1;
        strb[1] = 1'b1; mrw = 1'b1; maddr = 8'h51; mdin = 32'hFFFF_0000;
        @(posedge clk); #1;
        strb[1] = 1'b0;
        checks++;
        if ({rdy[1], bsy[1], perr[1]} !== 3'b001) begin errors++; $display("FAIL b2b_done_strobe got %b exp 001", {rdy[1], bsy[1], perr[1]}); end
        @(posedge clk); #1;
        checks++;
        if (bsy[1] !== 1'b0) begin errors++; $display("FAIL b2b_not_accepted got %b exp 0", bsy[1]); end
        checks++;
        if (dout[1] !== 32'h5050_5050) begin errors++; $display("FAIL b2b_read got %h exp 50505050", dout[1]); end
        run_req(1'b0, 8'h51, 32'h0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        bit         rw;
        for (int n = 0; n < 24; n++) begin
            a  = 8'h80 + 8'($urandom_range(0, 7));
            rw = !known[a] || 1'($urandom);
            run_req(rw, a, $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_latency_sweep();
        test_inputs_change();
        test_proto_err();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
